// File: rtl/raymarch_scheduler.sv
// Frame scheduler for a pool of raymarcher cores: hands out pixels in raster
// order, collects finished results round-robin and writes them to the frame buffer.
module raymarch_scheduler #(
  parameter int WIDTH     = 1280,
  parameter int HEIGHT    = 720,
  parameter int NUM_CORES = 3,
  localparam int XW = $clog2(WIDTH),
  localparam int YW = $clog2(HEIGHT),
  localparam int AW = $clog2(WIDTH * HEIGHT)
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    enable_in,
  output logic [NUM_CORES-1:0]    core_start_out,
  output logic [XW-1:0]           pix_x_out,
  output logic [YW-1:0]           pix_y_out,
  input  logic [NUM_CORES-1:0]    core_done_in,
  input  logic [24*NUM_CORES-1:0] core_color_in,
  input  logic [XW*NUM_CORES-1:0] core_x_in,
  input  logic [YW*NUM_CORES-1:0] core_y_in,
  output logic [NUM_CORES-1:0]    core_ack_out,
  output logic                    fb_we_out,
  output logic [AW-1:0]           fb_addr_out,
  output logic [23:0]             fb_data_out,
  output logic                    cam_latch_out,
  output logic [31:0]             frame_count_out,
  output logic                    busy_out
);

  localparam int PW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] LATCH    = 2'd1;
  localparam logic [1:0] DISPATCH = 2'd2;
  localparam logic [1:0] DRAIN    = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [XW-1:0]        x_q, x_d;
  logic [YW-1:0]        y_q, y_d;
  logic                 lastSent_q, lastSent_d;
  logic [NUM_CORES-1:0] busy_q, busy_d;
  logic [PW-1:0]        startPtr_q, startPtr_d;
  logic [PW-1:0]        ackPtr_q, ackPtr_d;
  logic [NUM_CORES-1:0] start_q, start_d;
  logic [NUM_CORES-1:0] ack_q, ack_d;
  logic [XW-1:0]        pixX_q, pixX_d;
  logic [YW-1:0]        pixY_q, pixY_d;
  logic                 we_q, we_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [23:0]          data_q, data_d;
  logic [31:0]          frameCount_q, frameCount_d;

  logic                 startHit, ackHit;
  logic [PW-1:0]        startIdx, ackIdx;
  logic [XW-1:0]        ackX;
  logic [YW-1:0]        ackY;
  logic [23:0]          ackColor;

  // First requester at or after ptr, wrapping around the core pool.
  function automatic logic [PW-1:0] rrPick(input logic [NUM_CORES-1:0] req,
                                           input logic [PW-1:0] ptr,
                                           output logic hit);
    int idx;
    rrPick = '0;
    hit    = 1'b0;
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NUM_CORES;
      if (req[idx]) begin
        rrPick = PW'(idx);
        hit    = 1'b1;
      end
    end
  endfunction

  function automatic logic [PW-1:0] rrNext(input logic [PW-1:0] idx);
    return PW'((int'(idx) + 1) % NUM_CORES);
  endfunction

  // Done from an idle core is stale or spurious, so only busy cores may be acked.
  always_comb begin
    startIdx = rrPick(~busy_q, startPtr_q, startHit);
    ackIdx   = rrPick(core_done_in & busy_q, ackPtr_q, ackHit);
  end

  assign ackX     = core_x_in[int'(ackIdx)*XW +: XW];
  assign ackY     = core_y_in[int'(ackIdx)*YW +: YW];
  assign ackColor = core_color_in[int'(ackIdx)*24 +: 24];

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    lastSent_d   = lastSent_q;
    busy_d       = busy_q;
    startPtr_d   = startPtr_q;
    ackPtr_d     = ackPtr_q;
    start_d      = '0;
    pixX_d       = '0;
    pixY_d       = '0;
    ack_d        = '0;
    we_d         = 1'b0;
    addr_d       = '0;
    data_d       = '0;
    frameCount_d = frameCount_q;

    case (state_q)
      IDLE: begin
        if (enable_in) state_d = LATCH;
      end
      LATCH: begin
        state_d    = DISPATCH;
        x_d        = '0;
        y_d        = '0;
        lastSent_d = 1'b0;
      end
      DISPATCH: begin
        if (lastSent_q) begin
          state_d = DRAIN;
        end else if (enable_in && startHit) begin
          start_d[startIdx] = 1'b1;
          busy_d[startIdx]  = 1'b1;
          pixX_d            = x_q;
          pixY_d            = y_q;
          startPtr_d        = rrNext(startIdx);
          if (x_q == XW'(WIDTH - 1)) begin
            x_d = '0;
            if (y_q == YW'(HEIGHT - 1)) begin
              y_d        = '0;
              lastSent_d = 1'b1;
            end else begin
              y_d = y_q + YW'(1);
            end
          end else begin
            x_d = x_q + XW'(1);
          end
        end
      end
      DRAIN: begin
        if (busy_q == '0 && core_done_in == '0) begin
          frameCount_d = frameCount_q + 32'd1;
          state_d      = enable_in ? LATCH : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Writeback runs independently of dispatch; the acked core is busy, so never the started one.
    if (state_q != IDLE && ackHit) begin
      ack_d[ackIdx]  = 1'b1;
      busy_d[ackIdx] = 1'b0;
      ackPtr_d       = rrNext(ackIdx);
      we_d           = 1'b1;
      addr_d         = AW'(ackX) + AW'(WIDTH) * AW'(ackY);
      data_d         = ackColor;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q      <= IDLE;
      x_q          <= '0;
      y_q          <= '0;
      lastSent_q   <= 1'b0;
      busy_q       <= '0;
      startPtr_q   <= '0;
      ackPtr_q     <= '0;
      start_q      <= '0;
      pixX_q       <= '0;
      pixY_q       <= '0;
      ack_q        <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      frameCount_q <= '0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      lastSent_q   <= lastSent_d;
      busy_q       <= busy_d;
      startPtr_q   <= startPtr_d;
      ackPtr_q     <= ackPtr_d;
      start_q      <= start_d;
      pixX_q       <= pixX_d;
      pixY_q       <= pixY_d;
      ack_q        <= ack_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      frameCount_q <= frameCount_d;
    end
  end

  assign core_start_out  = start_q;
  assign pix_x_out       = pixX_q;
  assign pix_y_out       = pixY_q;
  assign core_ack_out    = ack_q;
  assign fb_we_out       = we_q;
  assign fb_addr_out     = addr_q;
  assign fb_data_out     = data_q;
  assign cam_latch_out   = (state_q == LATCH);
  assign frame_count_out = frameCount_q;
  assign busy_out        = (state_q != IDLE);

endmodule

// File: tb/tb_raymarch_scheduler.sv
// Bench for raymarch_scheduler on a 4x2 frame with two behavioural cores whose
// result latency is tunable per test; starts, writes and latch pulses are logged.
`timescale 1ns/1ps
module tb_raymarch_scheduler;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int N  = 2;
  localparam int XW = 2;
  localparam int YW = 1;
  localparam int AW = 3;

  typedef struct {
    int          pix;
    int          expCore;
    int          expX;
    int          expY;
    int          expAddr;
    logic [23:0] expColor;
  } vector_t;

  typedef struct {int cyc; int core; int x; int y;} startEv_t;
  typedef struct {int cyc; int core; int we; int addr; int data;} writeEv_t;

  logic            clk, rst, enable;
  logic [N-1:0]    core_start_out, core_ack_out, core_done_in;
  logic [XW-1:0]   pix_x_out;
  logic [YW-1:0]   pix_y_out;
  logic [24*N-1:0] core_color_in;
  logic [XW*N-1:0] core_x_in;
  logic [YW*N-1:0] core_y_in;
  logic            fb_we_out, cam_latch_out, busy_out;
  logic [AW-1:0]   fb_addr_out;
  logic [23:0]     fb_data_out;
  logic [31:0]     frame_count_out;

  logic [N-1:0]    modelDone, spurDone;
  int              cnt[N];
  bit              pend[N];
  logic [XW-1:0]   mx[N];
  logic [YW-1:0]   my[N];
  logic [23:0]     colorArr[N];
  int              delayCfg[N];
  bit              slowLast;

  startEv_t        startLog[$];
  writeEv_t        writeLog[$];
  int              latchLog[$];
  int              latchFc[$];
  startEv_t        sEv;
  writeEv_t        wEv;
  vector_t         vecs[8];

  int              cycle = 0;
  int              checks = 0;
  int              errors = 0;
  int              idleNonZero = 0;
  int              nSeen;

  assign core_done_in  = modelDone | spurDone;
  assign core_color_in = {colorArr[1], colorArr[0]};
  assign core_x_in     = {mx[1], mx[0]};
  assign core_y_in     = {my[1], my[0]};

  raymarch_scheduler #(.WIDTH(W), .HEIGHT(H), .NUM_CORES(N)) dut (
    .clk_in(clk), .rst_in(rst), .enable_in(enable),
    .core_start_out(core_start_out), .pix_x_out(pix_x_out), .pix_y_out(pix_y_out),
    .core_done_in(core_done_in), .core_color_in(core_color_in),
    .core_x_in(core_x_in), .core_y_in(core_y_in), .core_ack_out(core_ack_out),
    .fb_we_out(fb_we_out), .fb_addr_out(fb_addr_out), .fb_data_out(fb_data_out),
    .cam_latch_out(cam_latch_out), .frame_count_out(frame_count_out), .busy_out(busy_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int oneHot(input logic [N-1:0] v);
    int idx = -1;
    int n = 0;
    for (int i = 0; i < N; i++) if (v[i]) begin idx = i; n++; end
    return (n == 1) ? idx : -1;
  endfunction

  // Monitor and core model both work on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    cycle = cycle + 1;
    if (core_start_out != '0) begin
      sEv.cyc = cycle; sEv.core = oneHot(core_start_out);
      sEv.x = int'(pix_x_out); sEv.y = int'(pix_y_out);
      startLog.push_back(sEv);
    end
    if (fb_we_out || core_ack_out != '0) begin
      wEv.cyc = cycle; wEv.core = oneHot(core_ack_out); wEv.we = int'(fb_we_out);
      wEv.addr = int'(fb_addr_out); wEv.data = int'(fb_data_out);
      writeLog.push_back(wEv);
    end
    if (cam_latch_out) begin
      latchLog.push_back(cycle);
      latchFc.push_back(int'(frame_count_out));
    end
    if (!fb_we_out && (fb_addr_out != '0 || fb_data_out != '0)) idleNonZero++;

    if (rst) begin
      modelDone = '0;
      for (int i = 0; i < N; i++) begin
        pend[i] = 1'b0; cnt[i] = 0; mx[i] = '0; my[i] = '0; colorArr[i] = '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (core_ack_out[i]) modelDone[i] = 1'b0;
        if (core_start_out[i]) begin
          pend[i] = 1'b1;
          mx[i]   = pix_x_out;
          my[i]   = pix_y_out;
          cnt[i]  = (slowLast && i == 1 && pix_x_out == 2'd3 && pix_y_out == 1'b1) ? 20 : delayCfg[i];
        end else if (pend[i]) begin
          cnt[i]--;
          if (cnt[i] == 0) begin
            pend[i]      = 1'b0;
            modelDone[i] = 1'b1;
            colorArr[i]  = {8'hA0, 6'd0, mx[i], 7'd0, my[i]};
          end
        end
      end
    end
  end

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_start"}, core_start_out, 0);
    checkOutput({tag, "_pixx"}, pix_x_out, 0);
    checkOutput({tag, "_pixy"}, pix_y_out, 0);
    checkOutput({tag, "_ack"}, core_ack_out, 0);
    checkOutput({tag, "_we"}, fb_we_out, 0);
    checkOutput({tag, "_addr"}, fb_addr_out, 0);
    checkOutput({tag, "_data"}, fb_data_out, 0);
    checkOutput({tag, "_latch"}, cam_latch_out, 0);
    checkOutput({tag, "_frames"}, frame_count_out, 0);
    checkOutput({tag, "_busy"}, busy_out, 0);
  endtask

  function automatic int logSize(input int which);
    case (which)
      0:       return startLog.size();
      1:       return writeLog.size();
      default: return latchLog.size();
    endcase
  endfunction

  task automatic waitUntil(input int which, input int n, input string name);
    int k = 0;
    while (k < 300 && logSize(which) < n) begin
      @(posedge clk);
      k++;
    end
    checkOutput(name, logSize(which) >= n, 1);
  endtask

  function automatic int countStartsBetween(input int lo, input int hi);
    int n = 0;
    foreach (startLog[i]) if (startLog[i].cyc > lo && startLog[i].cyc < hi) n++;
    return n;
  endfunction

  function automatic int countWritesBefore(input int c);
    int n = 0;
    foreach (writeLog[i]) if (writeLog[i].cyc < c) n++;
    return n;
  endfunction

  task automatic applyStimulus(input logic en, input int d0, input int d1, input bit slow);
    @(negedge clk); #2;
    rst = 1'b1; enable = 1'b0; spurDone = '0;
    delayCfg[0] = d0; delayCfg[1] = d1; slowLast = slow;
    @(negedge clk); #2;
    startLog.delete(); writeLog.delete(); latchLog.delete(); latchFc.delete();
    enable = en;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; enable = 1'b0; spurDone = '0;
    delayCfg[0] = 3; delayCfg[1] = 3; slowLast = 0;
    vecs[0] = '{0, 0, 0, 0, 0, 24'hA00000};
    vecs[1] = '{1, 1, 1, 0, 1, 24'hA00100};
    vecs[2] = '{2, 0, 2, 0, 2, 24'hA00200};
    vecs[3] = '{3, 1, 3, 0, 3, 24'hA00300};
    vecs[4] = '{4, 0, 0, 1, 4, 24'hA00001};
    vecs[5] = '{5, 1, 1, 1, 5, 24'hA00101};
    vecs[6] = '{6, 0, 2, 1, 6, 24'hA00201};
    vecs[7] = '{7, 1, 3, 1, 7, 24'hA00301};

    repeat (2) @(posedge clk);
    #1;
    checkAllZero("reset");

    // Whole frame with equal latency: starts and writes in raster order.
    applyStimulus(1'b1, 3, 3, 1'b0);
    waitUntil(2, 2, "frame_two_latches");
    if (latchLog.size() >= 2 && startLog.size() >= 8 && writeLog.size() >= 8) begin
      for (int i = 0; i < 8; i++) begin
        checkOutput($sformatf("frame_start%0d_core", vecs[i].pix), startLog[i].core, vecs[i].expCore);
        checkOutput($sformatf("frame_start%0d_x", vecs[i].pix), startLog[i].x, vecs[i].expX);
        checkOutput($sformatf("frame_start%0d_y", vecs[i].pix), startLog[i].y, vecs[i].expY);
        checkOutput($sformatf("frame_write%0d_we", vecs[i].pix), writeLog[i].we, 1);
        checkOutput($sformatf("frame_write%0d_core", vecs[i].pix), writeLog[i].core, vecs[i].expCore);
        checkOutput($sformatf("frame_write%0d_addr", vecs[i].pix), writeLog[i].addr, vecs[i].expAddr);
        checkOutput($sformatf("frame_write%0d_data", vecs[i].pix), writeLog[i].data, vecs[i].expColor);
      end
      checkOutput("frame_latch_before_first_start", latchLog[0] < startLog[0].cyc, 1);
      checkOutput("frame_latch_after_last_write", latchLog[1] > writeLog[7].cyc, 1);
      checkOutput("frame_starts_in_frame", countStartsBetween(latchLog[0], latchLog[1]), 8);
      checkOutput("frame_count_at_latch1", latchFc[1], 1);
      checkOutput("frame_count_at_latch0", latchFc[0], 0);
    end

    // Slow last pixel on core1 holds the frame in DRAIN.
    applyStimulus(1'b1, 3, 3, 1'b1);
    waitUntil(2, 2, "drain_two_latches");
    if (latchLog.size() >= 2 && startLog.size() >= 8 && writeLog.size() >= 8) begin
      checkOutput("drain_last_core", startLog[7].core, 1);
      checkOutput("drain_latch_after_slow", latchLog[1] > startLog[7].cyc + 20, 1);
      checkOutput("drain_latch_after_write", latchLog[1] > writeLog[7].cyc, 1);
      checkOutput("drain_last_addr", writeLog[7].addr, 7);
      checkOutput("drain_no_starts", countStartsBetween(startLog[7].cyc, latchLog[1]), 0);
      checkOutput("drain_frame_count", latchFc[1], 1);
    end

    // Different latencies so both cores finish in the same cycle.
    applyStimulus(1'b1, 4, 3, 1'b0);
    waitUntil(1, 4, "contention_writes");
    if (writeLog.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        checkOutput($sformatf("contention_w%0d_core", i), writeLog[i].core, i % 2);
        checkOutput($sformatf("contention_w%0d_addr", i), writeLog[i].addr, i);
      end
      checkOutput("contention_pair0_back_to_back", writeLog[1].cyc - writeLog[0].cyc, 1);
      checkOutput("contention_pair1_back_to_back", writeLog[3].cyc - writeLog[2].cyc, 1);
    end

    // Pause after three dispatches, then resume.
    applyStimulus(1'b1, 3, 3, 1'b0);
    nSeen = 0;
    for (int k = 0; k < 200 && nSeen < 3; k++) begin
      @(negedge clk);
      if (core_start_out != '0) nSeen++;
    end
    enable = 1'b0;
    checkOutput("pause_reached_three", nSeen, 3);
    repeat (30) @(posedge clk);
    checkOutput("pause_start_count", startLog.size(), 3);
    checkOutput("pause_write_count", writeLog.size(), 3);
    if (writeLog.size() >= 3)
      for (int i = 0; i < 3; i++) checkOutput($sformatf("pause_w%0d_addr", i), writeLog[i].addr, i);
    enable = 1'b1;
    waitUntil(0, 4, "pause_resume");
    if (startLog.size() >= 4) begin
      checkOutput("pause_resume_x", startLog[3].x, 3);
      checkOutput("pause_resume_y", startLog[3].y, 0);
    end

    // Asynchronous reset in the middle of the second frame.
    applyStimulus(1'b1, 3, 3, 1'b0);
    waitUntil(2, 2, "areset_first_frame");
    waitUntil(0, 10, "areset_second_frame_started");
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    checkAllZero("areset");
    @(negedge clk); #2;
    startLog.delete(); writeLog.delete(); latchLog.delete(); latchFc.delete();
    rst = 1'b0;
    waitUntil(0, 1, "areset_restart");
    if (startLog.size() >= 1 && latchLog.size() >= 1) begin
      checkOutput("areset_latch_first", latchLog[0] < startLog[0].cyc, 1);
      checkOutput("areset_restart_x", startLog[0].x, 0);
      checkOutput("areset_restart_y", startLog[0].y, 0);
      checkOutput("areset_frame_count", latchFc[0], 0);
      checkOutput("areset_no_stale_acks", countWritesBefore(startLog[0].cyc), 0);
    end

    // Spurious done from an idle core must be ignored.
    applyStimulus(1'b1, 3, 3, 1'b0);
    spurDone = 2'b10;
    repeat (3) @(negedge clk);
    #2;
    spurDone = '0;
    waitUntil(1, 1, "spurious_first_write");
    if (writeLog.size() >= 1) begin
      checkOutput("spurious_first_core", writeLog[0].core, 0);
      checkOutput("spurious_first_addr", writeLog[0].addr, 0);
      checkOutput("spurious_first_data", writeLog[0].data, 24'hA00000);
    end

    checkOutput("idle_bus_zero", idleNonZero, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
